// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receive port.
package uart_pkg;

  localparam logic [15:0] UART_DATA_ADDR = 16'h5a00;
  localparam logic [15:0] UART_STAT_ADDR = 16'h5a01;

  localparam int RDY  = 0;
  localparam int OVR  = 1;
  localparam int FERR = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: two-flop synchroniser, receive FSM and shift register.
// Emits a one-cycle byte_valid or frame_err pulse on the stop-sample edge.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge on rxs
// RX_START     | half a bit in; confirms start bit or rejects a glitch
// RX_DATA      | sampling 8 data bits LSB first, one per bit period
// RX_STOP      | one bit period on, samples the stop bit
// RX_WAIT_HIGH | framing error seen; waits for the line to return high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q;
  logic            rxs_q;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            stop_tick;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (!rxs_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rxs_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rxs_q;
            idx_q          <= idx_q + 1'b1;
            if (idx_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= rxs_q ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // Decoded from registered state so the port can act on the sample edge itself
  assign stop_tick    = (state_q == RX_STOP) && (cnt_q == BIT_LAST);
  assign byte_valid_o = stop_tick && rxs_q;
  assign frame_err_o  = stop_tick && !rxs_q;
  assign rx_byte_o    = shift_q;

endmodule

// File: rtl/uart_rx_port.sv
// CPU-bus console input: holding register, status flags and a
// combinational read path at BASE_ADDR (data) and BASE_ADDR+1 (status).
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [15:0] BASE_ADDR    = UART_DATA_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] address,
  input  logic        read_en,
  output logic [7:0]  data_out,
  output logic        rx_irq
);

  localparam logic [15:0] STAT_ADDR = BASE_ADDR + (UART_STAT_ADDR - UART_DATA_ADDR);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  logic [7:0] hold_q, hold_d;
  logic       rdy_q, rdy_d;
  logic       ovr_q, ovr_d;
  logic       ferr_q, ferr_d;
  logic [7:0] status;
  logic       data_rd;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clock_i      (clock),
    .reset_i      (reset),
    .rx_i         (rx),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err)
  );

  assign data_rd = read_en && (address == BASE_ADDR);

  // A data read clears the flags before a same-cycle completion is applied
  always_comb begin
    hold_d = hold_q;
    rdy_d  = data_rd ? 1'b0 : rdy_q;
    ovr_d  = data_rd ? 1'b0 : ovr_q;
    ferr_d = data_rd ? 1'b0 : ferr_q;
    if (byte_valid) begin
      if (rdy_d) begin
        ovr_d = 1'b1;
      end else begin
        hold_d = rx_byte;
        rdy_d  = 1'b1;
      end
    end
    if (frame_err) ferr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= 8'h00;
      rdy_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rdy_q  <= rdy_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    status       = 8'h00;
    status[RDY]  = rdy_q;
    status[OVR]  = ovr_q;
    status[FERR] = ferr_q;
    data_out     = 8'h00;
    if (address == BASE_ADDR)      data_out = hold_q;
    else if (address == STAT_ADDR) data_out = status;
  end

  assign rx_irq = rdy_q;

endmodule
